// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - native memory bus bundle (valid/ready/addr/wdata/wstrb/rdata)
// Purpose: one request/response channel of the native memory bus.
// Ports (signals):
//   valid  requester -> responder  request, held until ready
//   addr   requester -> responder  32-bit byte address
//   wdata  requester -> responder  32-bit write data
//   wstrb  requester -> responder  byte strobes, 0 = read
//   ready  responder -> requester  completion pulse
//   rdata  responder -> requester  read data, valid with ready
// Modports: master = requester side, slave = responder side.
interface mem_bus_arbiter_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master native memory bus arbiter with grant lock and slave watchdog
// Purpose: shares one memory-bus slave between m0 (core) and m1 (debug loader).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   m0, m1        slave-side bus ports facing the two requesters
//   s             master-side bus port facing the shared slave
//   grant         one-hot bus owner, 00 when idle
//   timeout_err   sticky watchdog error flag
//   timeout_addr  address of the first timed-out access since the last clear
//   err_clr       clears timeout_err / timeout_addr
module mem_bus_arbiter #(
  parameter int          PRIORITY_MODE  = 0,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_bus_arbiter_if.slave        m0,
  mem_bus_arbiter_if.slave        m1,
  mem_bus_arbiter_if.master       s,
  output logic [1:0]              grant,
  output logic                    timeout_err,
  output logic [31:0]             timeout_addr,
  input  logic                    err_clr
);

  // The watchdog leaves BUSY at TIMEOUT_CYCLES-1, so this width never wraps.
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic            last_grant;   // 0 = m0 owned last, 1 = m1 owned last
  logic [WD_W-1:0] wdog;

  logic        busy;
  logic        g_valid;
  logic        done;
  logic        timeout_hit;
  logic        finish;
  logic        pick_m1;
  logic [31:0] cpl_rdata;

  always_comb begin
    busy    = (state == BUSY);
    g_valid = 1'b0;
    s.addr  = '0;
    s.wdata = '0;
    s.wstrb = '0;
    if (grant[0]) begin
      g_valid = m0.valid;
      s.addr  = m0.addr;
      s.wdata = m0.wdata;
      s.wstrb = m0.wstrb;
    end else if (grant[1]) begin
      g_valid = m1.valid;
      s.addr  = m1.addr;
      s.wdata = m1.wdata;
      s.wstrb = m1.wstrb;
    end

    // A slave response in the last watchdog cycle still counts as a normal completion.
    done        = busy && s.ready;
    timeout_hit = (TIMEOUT_CYCLES != 0) && busy && !s.ready &&
                  (wdog == WD_W'(TIMEOUT_CYCLES - 1));
    finish      = done || timeout_hit;

    // On timeout the request is withdrawn from the slave in the same cycle it is answered.
    s.valid   = busy && g_valid && !timeout_hit;
    cpl_rdata = done ? s.rdata : ERR_RDATA;

    m0.ready = finish && grant[0];
    m1.ready = finish && grant[1];
    m0.rdata = (finish && grant[0]) ? cpl_rdata : '0;
    m1.rdata = (finish && grant[1]) ? cpl_rdata : '0;

    // m1 wins when alone, or on a round-robin tie when m0 owned the bus last.
    pick_m1 = m1.valid && (!m0.valid || ((PRIORITY_MODE == 0) && !last_grant));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= 2'b00;
      last_grant   <= 1'b1;
      wdog         <= '0;
      timeout_err  <= 1'b0;
      timeout_addr <= '0;
    end else begin
      if (err_clr) begin
        timeout_err  <= 1'b0;
        timeout_addr <= '0;
      end
      case (state)
        IDLE: begin
          if (m0.valid || m1.valid) begin
            grant <= pick_m1 ? 2'b10 : 2'b01;
            wdog  <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (finish) begin
            last_grant <= grant[1];
            grant      <= 2'b00;
            state      <= IDLE;
            if (timeout_hit) begin
              // A new error overrides a simultaneous clear; otherwise the first address is kept.
              timeout_err <= 1'b1;
              if (!timeout_err || err_clr)
                timeout_addr <= s.addr;
            end
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - model-checked bench for mem_bus_arbiter (round-robin and fixed-priority instances)
module tb_mem_bus_arbiter;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk;
  logic        rst;
  logic        err_clr;
  logic        m0_valid, m1_valid, s_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;

  mem_bus_arbiter_if rr_m0();
  mem_bus_arbiter_if rr_m1();
  mem_bus_arbiter_if rr_s();
  mem_bus_arbiter_if fx_m0();
  mem_bus_arbiter_if fx_m1();
  mem_bus_arbiter_if fx_s();

  logic [1:0]  rr_grant, fx_grant;
  logic        rr_terr, fx_terr;
  logic [31:0] rr_taddr, fx_taddr;

  assign rr_m0.valid = m0_valid;  assign fx_m0.valid = m0_valid;
  assign rr_m0.addr  = m0_addr;   assign fx_m0.addr  = m0_addr;
  assign rr_m0.wdata = m0_wdata;  assign fx_m0.wdata = m0_wdata;
  assign rr_m0.wstrb = m0_wstrb;  assign fx_m0.wstrb = m0_wstrb;
  assign rr_m1.valid = m1_valid;  assign fx_m1.valid = m1_valid;
  assign rr_m1.addr  = m1_addr;   assign fx_m1.addr  = m1_addr;
  assign rr_m1.wdata = m1_wdata;  assign fx_m1.wdata = m1_wdata;
  assign rr_m1.wstrb = m1_wstrb;  assign fx_m1.wstrb = m1_wstrb;
  assign rr_s.ready  = s_ready;   assign fx_s.ready  = s_ready;
  assign rr_s.rdata  = s_rdata;   assign fx_s.rdata  = s_rdata;

  mem_bus_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) u_rr (
    .clk(clk), .rst(rst), .m0(rr_m0), .m1(rr_m1), .s(rr_s),
    .grant(rr_grant), .timeout_err(rr_terr), .timeout_addr(rr_taddr), .err_clr(err_clr));

  mem_bus_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) u_fx (
    .clk(clk), .rst(rst), .m0(fx_m0), .m1(fx_m1), .s(fx_s),
    .grant(fx_grant), .timeout_err(fx_terr), .timeout_addr(fx_taddr), .err_clr(err_clr));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [1:0]  grant;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        m0_ready;
    logic [31:0] m0_rdata;
    logic        m1_ready;
    logic [31:0] m1_rdata;
    logic        terr;
    logic [31:0] taddr;
  } obs_t;

  int n_checks = 0;
  int n_err    = 0;
  obs_t snap[2];

  // Reference model per instance (index 0 = round-robin, 1 = fixed priority).
  int          owner[2];   // -1 idle, else owning master number
  int          waited[2];  // busy cycles already spent without a slave response
  int          last[2];    // master that owned the bus most recently
  bit          err[2];
  logic [31:0] eaddr[2];

  function automatic obs_t get_obs(int md);
    obs_t o;
    if (md == 0) begin
      o.grant = rr_grant; o.s_valid = rr_s.valid; o.s_addr = rr_s.addr;
      o.s_wdata = rr_s.wdata; o.s_wstrb = rr_s.wstrb;
      o.m0_ready = rr_m0.ready; o.m0_rdata = rr_m0.rdata;
      o.m1_ready = rr_m1.ready; o.m1_rdata = rr_m1.rdata;
      o.terr = rr_terr; o.taddr = rr_taddr;
    end else begin
      o.grant = fx_grant; o.s_valid = fx_s.valid; o.s_addr = fx_s.addr;
      o.s_wdata = fx_s.wdata; o.s_wstrb = fx_s.wstrb;
      o.m0_ready = fx_m0.ready; o.m0_rdata = fx_m0.rdata;
      o.m1_ready = fx_m1.ready; o.m1_rdata = fx_m1.rdata;
      o.terr = fx_terr; o.taddr = fx_taddr;
    end
    return o;
  endfunction

  function automatic obs_t model_out(int md);
    obs_t e;
    bit   gv, tmo, fin;
    e   = '0;
    gv  = 1'b0;
    fin = (owner[md] >= 0) && s_ready;
    tmo = (owner[md] >= 0) && !s_ready && (waited[md] == TO - 1);
    if (owner[md] == 0) begin
      e.grant = 2'b01; gv = m0_valid;
      e.s_addr = m0_addr; e.s_wdata = m0_wdata; e.s_wstrb = m0_wstrb;
    end else if (owner[md] == 1) begin
      e.grant = 2'b10; gv = m1_valid;
      e.s_addr = m1_addr; e.s_wdata = m1_wdata; e.s_wstrb = m1_wstrb;
    end
    e.s_valid = gv && !tmo;
    if (fin || tmo) begin
      if (owner[md] == 0) begin e.m0_ready = 1'b1; e.m0_rdata = fin ? s_rdata : ERR; end
      else                begin e.m1_ready = 1'b1; e.m1_rdata = fin ? s_rdata : ERR; end
    end
    e.terr  = err[md];
    e.taddr = eaddr[md];
    return e;
  endfunction

  task automatic model_reset();
    for (int md = 0; md < 2; md++) begin
      owner[md] = -1; waited[md] = 0; last[md] = 1; err[md] = 1'b0; eaddr[md] = '0;
    end
  endtask

  task automatic model_step(int md);
    bit          fin, tmo, had_err;
    logic [31:0] cur_addr;
    if (rst) begin
      owner[md] = -1; waited[md] = 0; last[md] = 1; err[md] = 1'b0; eaddr[md] = '0;
      return;
    end
    fin      = (owner[md] >= 0) && s_ready;
    tmo      = (owner[md] >= 0) && !s_ready && (waited[md] == TO - 1);
    cur_addr = (owner[md] == 0) ? m0_addr : m1_addr;
    had_err  = err[md];
    if (err_clr) begin err[md] = 1'b0; eaddr[md] = '0; end
    if (owner[md] < 0) begin
      if (m0_valid && m1_valid) owner[md] = (md == 1) ? 0 : 1 - last[md];
      else if (m0_valid)        owner[md] = 0;
      else if (m1_valid)        owner[md] = 1;
      waited[md] = 0;
    end else if (fin || tmo) begin
      if (tmo) begin
        if (!had_err || err_clr) eaddr[md] = cur_addr;
        err[md] = 1'b1;
      end
      last[md]  = owner[md];
      owner[md] = -1;
    end else begin
      waited[md]++;
    end
  endtask

  task automatic chk(input string name, input int md, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[inst %0d] t=%0t: got %h expected %h", name, md, $time, act, exp);
    end
  endtask

  // One clock cycle: outputs are compared mid-cycle with the inputs already applied,
  // then the model advances the same way the clock edge advances the DUT.
  task automatic step();
    obs_t o, e;
    @(negedge clk);
    #1;
    for (int md = 0; md < 2; md++) begin
      o = get_obs(md);
      e = model_out(md);
      snap[md] = o;
      chk("grant",        md, 32'(o.grant),    32'(e.grant));
      chk("s_valid",      md, 32'(o.s_valid),  32'(e.s_valid));
      chk("s_addr",       md, o.s_addr,        e.s_addr);
      chk("s_wdata",      md, o.s_wdata,       e.s_wdata);
      chk("s_wstrb",      md, 32'(o.s_wstrb),  32'(e.s_wstrb));
      chk("m0_ready",     md, 32'(o.m0_ready), 32'(e.m0_ready));
      chk("m0_rdata",     md, o.m0_rdata,      e.m0_rdata);
      chk("m1_ready",     md, 32'(o.m1_ready), 32'(e.m1_ready));
      chk("m1_rdata",     md, o.m1_rdata,      e.m1_rdata);
      chk("timeout_err",  md, 32'(o.terr),     32'(e.terr));
      chk("timeout_addr", md, o.taddr,         e.taddr);
      model_step(md);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [1:0] rr_pat [4];

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready = 1'b0; s_rdata = '0;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    step();
    chk("reset_grant",   0, 32'(snap[0].grant),   32'h0);
    chk("reset_s_valid", 0, 32'(snap[0].s_valid), 32'h0);
    chk("reset_terr",    1, 32'(snap[1].terr),    32'h0);

    // m0 read, slave answers on the third busy cycle
    m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    step();
    chk("t1_idle_s_valid", 0, 32'(snap[0].s_valid), 32'h0);
    step();
    chk("t1_grant",   0, 32'(snap[0].grant),   32'h1);
    chk("t1_s_valid", 0, 32'(snap[0].s_valid), 32'h1);
    step();
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    step();
    chk("t1_m0_ready", 0, 32'(snap[0].m0_ready), 32'h1);
    chk("t1_m0_rdata", 0, snap[0].m0_rdata,      32'h1234_5678);
    m0_valid = 1'b0; s_ready = 1'b0;
    step();
    chk("t1_grant_after", 0, 32'(snap[0].grant),    32'h0);
    chk("t1_ready_after", 0, 32'(snap[0].m0_ready), 32'h0);

    // Both masters requesting continuously with an always-ready slave
    do_reset();
    rr_pat = '{2'b01, 2'b10, 2'b01, 2'b10};
    m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1; s_rdata = 32'hCAFE_0000;
    m0_addr = 32'h0000_0200; m1_addr = 32'h0000_0300;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_idle_grant", 0, 32'(snap[0].grant), 32'h0);
      step();
      chk("t2_rr_grant",   0, 32'(snap[0].grant),    32'(rr_pat[k]));
      chk("t2_rr_m1_rdy",  0, 32'(snap[0].m1_ready), 32'(rr_pat[k][1]));
      chk("t3_fx_grant",   1, 32'(snap[1].grant),    32'h1);
      chk("t3_fx_m1_rdy",  1, 32'(snap[1].m1_ready), 32'h0);
    end

    // m1 write to a slave that never answers
    do_reset();
    m1_valid = 1'b1; m1_addr = 32'h3000_0000; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'hF;
    step();
    for (int c = 1; c <= TO; c++) begin
      step();
      chk("t4_m1_ready", 0, 32'(snap[0].m1_ready), (c == TO) ? 32'h1 : 32'h0);
      chk("t4_s_valid",  0, 32'(snap[0].s_valid),  (c == TO) ? 32'h0 : 32'h1);
    end
    chk("t4_m1_rdata", 0, snap[0].m1_rdata, 32'hDEAD_BEEF);
    m1_valid = 1'b0;
    step();
    chk("t4_terr",  0, 32'(snap[0].terr), 32'h1);
    chk("t4_taddr", 0, snap[0].taddr,     32'h3000_0000);

    // Second timeout keeps the first address
    m1_valid = 1'b1; m1_addr = 32'h3000_0004;
    for (int c = 0; c <= TO; c++) step();
    m1_valid = 1'b0;
    step();
    chk("t5_taddr_kept", 0, snap[0].taddr, 32'h3000_0000);

    // Third timeout coinciding with err_clr
    m1_valid = 1'b1; m1_addr = 32'h3000_0008;
    for (int c = 0; c < TO; c++) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0; m1_valid = 1'b0;
    step();
    chk("t5_terr_set",  0, 32'(snap[0].terr), 32'h1);
    chk("t5_taddr_new", 1, snap[1].taddr,     32'h3000_0008);

    // Reset in the middle of a transaction, then a late slave response
    m0_valid = 1'b1; m0_addr = 32'h0000_0400;
    step();
    step();
    chk("t6_busy", 0, 32'(snap[0].s_valid), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0; m0_valid = 1'b0; s_ready = 1'b1;
    step();
    chk("t6_no_ready", 0, 32'(snap[0].m0_ready), 32'h0);
    chk("t6_grant",    0, 32'(snap[0].grant),    32'h0);
    m0_valid = 1'b1; m1_valid = 1'b1;
    step();
    step();
    chk("t6_tie_m0", 0, 32'(snap[0].grant), 32'h1);
    idle_inputs();
    step();

    // Randomised traffic: segments alternate a responsive and a sluggish slave
    for (int seg = 0; seg < 6; seg++) begin
      int dens;
      dens = (seg % 2 == 1) ? 9 : 2;
      for (int i = 0; i < 500; i++) begin
        rst     = ($urandom_range(0, 299) == 0);
        err_clr = ($urandom_range(0, 15) == 0);
        if (!m0_valid) begin
          if ($urandom_range(0, 2) == 0) begin
            m0_valid = 1'b1; m0_addr = $urandom; m0_wdata = $urandom;
            m0_wstrb = 4'($urandom_range(0, 15));
          end
        end else if ($urandom_range(0, 5) == 0) m0_valid = 1'b0;
        if (!m1_valid) begin
          if ($urandom_range(0, 2) == 0) begin
            m1_valid = 1'b1; m1_addr = $urandom; m1_wdata = $urandom;
            m1_wstrb = 4'($urandom_range(0, 15));
          end
        end else if ($urandom_range(0, 5) == 0) m1_valid = 1'b0;
        s_ready = ($urandom_range(0, dens - 1) == 0);
        s_rdata = $urandom;
        step();
      end
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
